// File: rtl/pattern_scan_if.sv
// pattern_scan_if: byte stream handshake into the pattern scan controller
interface pattern_scan_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    modport master (output in_valid, in_data, in_last, input in_ready);
    modport slave (input in_valid, in_data, in_last, output in_ready);
endinterface

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: serializes bytes MSB first and counts overlapping pattern matches per frame
module pattern_scan_ctrl (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_we,
    input  logic [7:0]           cfg_pattern,
    input  logic [3:0]           cfg_len,
    pattern_scan_if.slave        stream,
    output logic                 det_x,
    output logic                 match_pulse,
    output logic [7:0]           match_count,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [7:0] sreg, history, pat_q, mask, hist_n;
    logic [3:0] len_q, leff, fbits, fbits_n;
    logic [2:0] bitcnt;
    logic       last_q, accept, hit;
    assign accept = state == IDLE && stream.in_valid;
    assign stream.in_ready = state == IDLE && !rst;
    assign det_x = state == SHIFT && sreg[7];
    assign done = state == DONE;
    assign leff = len_q == 4'd0 ? 4'd1 : (len_q > 4'd8 ? 4'd8 : len_q);
    assign mask = ~(8'hFF << leff);
    assign hist_n = {history[6:0], sreg[7]};
    assign fbits_n = fbits + {3'd0, fbits != 4'd8};
    assign hit = state == SHIFT && ((hist_n ^ pat_q) & mask) == 8'd0 && fbits_n >= leff;
    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    // next state: one accept edge, eight shift edges, optional done cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = accept ? SHIFT : IDLE;
            SHIFT:   state_n = bitcnt == 3'd7 ? (last_q ? DONE : IDLE) : SHIFT;
            default: state_n = IDLE;
        endcase
    end
    // datapath: config capture, serialization, history and match counting
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg        <= 8'd0;
            history     <= 8'd0;
            pat_q       <= 8'h00;
            len_q       <= 4'd1;
            fbits       <= 4'd0;
            bitcnt      <= 3'd0;
            last_q      <= 1'b0;
            match_pulse <= 1'b0;
            match_count <= 8'd0;
            busy        <= 1'b0;
        end else begin
            if (cfg_we && !busy) begin
                pat_q <= cfg_pattern;
                len_q <= cfg_len;
            end
            match_pulse <= hit;
            if (accept) begin
                sreg   <= stream.in_data;
                last_q <= stream.in_last;
                bitcnt <= 3'd0;
                busy   <= 1'b1;
                if (!busy) match_count <= 8'd0;
            end else if (state == SHIFT) begin
                sreg    <= {sreg[6:0], 1'b0};
                bitcnt  <= bitcnt + 3'd1;
                history <= hist_n;
                fbits   <= fbits_n;
                if (hit && match_count != 8'hFF) match_count <= match_count + 8'd1;
            end else if (state == DONE) begin
                history <= 8'd0;
                fbits   <= 4'd0;
                busy    <= 1'b0;
            end
        end
    end
endmodule

// File: doc/pattern_scan_ctrl.md
PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

Interface
REQ-001 SHALL have parameter: none; pattern width fixed at 8 bits, byte width fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cfg_we  input  1  write strobe for cfg_pattern/cfg_len.
REQ-005 cfg_pattern  input  8  target pattern; bit 0 = most recent bit.
REQ-006 cfg_len  input  4  pattern length in bits.
REQ-007 in_valid  input  1  byte offered.
REQ-008 in_data  input  8  byte, serialized MSB first.
REQ-009 in_last  input  1  byte is last of frame; sampled with in_data.
REQ-010 in_ready  output  1  controller can accept a byte.
REQ-011 det_x  output  1  serial bit currently driven to the detector.
REQ-012 match_pulse  output  1  one-cycle match indication.
REQ-013 match_count  output  8  matches in current/last frame.
REQ-014 busy  output  1  frame in progress.
REQ-015 done  output  1  one-cycle frame-complete strobe.

Function
REQ-016 SHALL implement states IDLE, SHIFT and DONE.
REQ-017 IDLE: in_ready=1; in_valid&in_ready at edge E0 SHALL load in_data, latch in_last, clear bit counter, go to SHIFT.
REQ-018 SHIFT: in_ready=0; det_x = current MSB of the shift register (combinational); in_valid ignored.
REQ-019 Edges E1..E8 after accept SHALL each shift det_x into the 8-bit history (history = {history[6:0], det_x}).
REQ-020 At E8: in_last latched=0 -> IDLE with history kept; in_last latched=1 -> DONE.
REQ-021 DONE: done=1 for exactly one cycle; next edge -> IDLE, history and frame bit count cleared.
REQ-022 busy SHALL be 1 from the cycle after the first byte of a frame is accepted through the DONE cycle, inclusive.
REQ-023 Effective length L = 1 if cfg_len=0, 8 if cfg_len>8, else cfg_len.
REQ-024 Match at edge Ek when the low L bits of updated history equal the low L bits of cfg_pattern and frame bit count (incl. this bit) >= L; overlapping matches counted.
REQ-025 match_pulse SHALL be registered: high for exactly the one cycle after the matching edge.
REQ-026 Matches SHALL span byte boundaries within a frame; never across frames.
REQ-027 match_count SHALL clear at acceptance of the first byte of a frame, increment per match, saturate at 255, hold after DONE until next frame.
REQ-028 cfg_we SHALL be honoured only when busy=0; ignored otherwise (config stable for whole frame).
REQ-029 Simultaneous cfg_we and byte accept in IDLE at frame start: new config SHALL apply to that frame.

Reset
REQ-030 rst high at an edge SHALL force IDLE; in_ready=0 while rst high, 1 after release.
REQ-031 Reset values: det_x=0, match_pulse=0, match_count=0, busy=0, done=0, history=0, cfg_pattern=8'h00, cfg_len=4'd1.
REQ-032 rst mid-SHIFT SHALL abandon the frame with no done pulse.

Verification
REQ-033 cfg 1011/L=4, one byte 0xB6 last -> match_pulse after E4 and E7, match_count=2, done one cycle after E8.
REQ-034 cfg 1011/L=4, frame 0x01 then 0x60 last -> single match on 3rd bit of second byte, match_count=1.
REQ-035 cfg pattern 0x01/L=1, 32 bytes 0xFF, last on 32nd -> match_count saturates at 255.
REQ-036 cfg_we (pattern 0x00) asserted during SHIFT -> ignored; original pattern results unchanged.
REQ-037 in_valid held high throughout -> exactly one byte accepted per 9 cycles; in_ready=0 during all SHIFT cycles.
REQ-038 rst asserted at E3 of a byte -> next cycle all outputs at reset values, no done; next frame counts from 0.
